bp_update_queue: RTL and testbench
==================================

Name: bp_update_queue

Overview:
- Commit-side update stage for the bimodal branch-predictor counter table.
- Each entry accepts one resolved conditional branch per cycle: table index, counter value read at predict time, and actual outcome.
- Computes the saturated new counter, coalesces with pending updates to the same index, and buffers results in a small FIFO.
- Drains one write per cycle into the counter RAM write port (address, data, write-enable).

Parameters:
- DEPTH, 64, entries in the counter table.
- INDEX, 6, table index width (log2 DEPTH).
- CTR_WIDTH, 2, saturating counter width.
- QDEPTH, 4, update FIFO entries (power of 2, >=2).
- QIDX, 2, log2 QDEPTH.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- upd_valid_i  in  1  resolved-branch update present.
- upd_index_i  in  INDEX  table index of the branch.
- upd_ctr_i  in  CTR_WIDTH  counter value read at predict time.
- upd_taken_i  in  1  actual branch outcome.
- upd_ready_o  out  1  queue can accept an update this cycle.
- stall_i  in  1  inhibit RAM writes this cycle.
- wr_index_o  out  INDEX  to counter RAM write address.
- wr_data_o  out  CTR_WIDTH  to counter RAM write data.
- wr_en_o  out  1  to counter RAM write enable.

Behaviour:
- Reset (synchronous, active-high, clock clk): head, tail and count clear to 0; all entry valid bits clear.
  - While reset is high: upd_ready_o=0, wr_en_o=0, wr_index_o=0, wr_data_o=CTR_RESET (2).
  - Reset mid-operation discards all pending updates. This matches the table reset value of 2 (weakly taken).
- Saturation: new = taken ? min(base+1, 2^CTR_WIDTH-1) : max(base-1, 0). Unsigned; no wrap at 3 or 0.
- Base selection: base = new value held by the youngest valid queue entry whose index equals upd_index_i; otherwise upd_ctr_i. This corrects a stale predict-time read.
- upd_ready_o = !full && !reset. It does not depend on upd_valid_i.
- Enqueue occurs when upd_valid_i && upd_ready_o.
  - Coalesce: if the matching entry is not the head being drained this cycle, its data is overwritten in place with new. No allocation; count unchanged.
  - Otherwise (no match, or match is the draining head): allocate at tail with {upd_index_i, new}; tail advances with wrap modulo QDEPTH.
- Drain: wr_en_o = !empty && !stall_i. wr_index_o and wr_data_o come combinationally from the head entry.
  - When wr_en_o=1, head advances (wraps) at the clock edge.
  - When empty, wr_data_o/wr_index_o hold the last head contents; they are don't-care while wr_en_o=0.
- Latency: an update accepted at edge N appears on the write port in cycle N+1 at the earliest. Zero-cycle bypass is not allowed.
- Full: upd_ready_o=0 even if a drain occurs the same cycle (no pass-through). Upstream holds the update.
- Simultaneous enqueue and drain: count unchanged. A coalesce into the draining head is forbidden (see above).
- stall_i=1: no writes; enqueue and coalesce continue normally.
- Upstream holds upd_valid_i and its data stable until accepted.

Optional Feature:
- Macro BP_UPD_STATS_EN.
- When defined, adds two outputs: stat_coalesce_o (32 bits), counting accepted updates that coalesced, and stat_full_o (32 bits), counting cycles with upd_valid_i && !upd_ready_o.
  - Both counters reset to 0, saturate at 2^32-1, and are updated synchronously.
- When not defined, these ports and counters do not exist. Functional behaviour is identical either way.

Decomposition:
- Package bp_pkg contains:
  - CTR_WIDTH, CTR_MAX, CTR_RESET=2.
  - typedef bp_upd_entry_t {valid, index, ctr}.
  - Function bp_sat_next(ctr, taken).
- One sub-module is natural: bp_upd_fifo, the circular storage with head/tail/count and a youngest-match search port.
- Coalesce and saturation logic live in bp_update_queue.

Test Plan:
- Reset, then a single update idx=5, ctr=2, taken=1 -> next cycle wr_en_o=1, wr_index_o=5, wr_data_o=3; queue empty after.
- Saturation: update idx=1, ctr=3, taken=1 -> wr_data_o=3. Update idx=2, ctr=0, taken=0 -> wr_data_o=0.
- Coalesce under stall_i=1: updates to idx=7 with ctr=1, taken=1, in three consecutive cycles -> count stays 1. Release stall -> exactly one write, idx=7, data=3.
- Fill: stall_i=1, then 4 distinct indices accepted -> upd_ready_o=0. Fifth update is held. Release stall -> drain writes in order, and the fifth is accepted the cycle after the first drain.
- Head-drain match: head idx=9 data=2 draining while update idx=9, ctr=1, taken=0 arrives -> new entry allocated with data=1 (base taken from head). Writes are 9/2, then 9/1.
- Reset asserted with 3 entries pending -> wr_en_o=0 on the next cycle, upd_ready_o=0 during reset; after release, no writes occur.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared widths, entry record and saturating-counter helper for the bimodal predictor update path.
package bp_pkg;

  localparam int DEPTH     = 64;
  localparam int INDEX     = 6;
  localparam int CTR_WIDTH = 2;
  localparam int BP_QDEPTH = 4;
  localparam int BP_QIDX   = 2;

  localparam logic [CTR_WIDTH-1:0] CTR_MAX   = '1;
  localparam logic [CTR_WIDTH-1:0] CTR_RESET = CTR_WIDTH'(2);

  typedef struct packed {
    logic                 valid;
    logic [INDEX-1:0]     index;
    logic [CTR_WIDTH-1:0] ctr;
  } bp_upd_entry_t;

  function automatic logic [CTR_WIDTH-1:0] bp_sat_next(input logic [CTR_WIDTH-1:0] ctr,
                                                        input logic                 taken);
    if (taken) return (ctr == CTR_MAX) ? ctr : ctr + 1'b1;
    else       return (ctr == '0)      ? ctr : ctr - 1'b1;
  endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Circular update buffer (head/tail/count) with in-place rewrite and a youngest-index-match search.
// Writes land at the clock edge; push when full and pop when empty are excluded by the caller.
module bp_upd_fifo
  import bp_pkg::*;
#(
  parameter int QDEPTH = BP_QDEPTH,
  parameter int QIDX   = BP_QIDX
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_push,
  input  logic [INDEX-1:0]     i_push_index,
  input  logic [CTR_WIDTH-1:0] i_push_ctr,
  input  logic                 i_pop,
  input  logic                 i_upd_en,
  input  logic [QIDX-1:0]      i_upd_ptr,
  input  logic [CTR_WIDTH-1:0] i_upd_ctr,
  input  logic [INDEX-1:0]     i_srch_index,
  output logic                 o_match,
  output logic [QIDX-1:0]      o_match_ptr,
  output logic                 o_match_is_head,
  output logic [CTR_WIDTH-1:0] o_match_ctr,
  output logic [INDEX-1:0]     o_head_index,
  output logic [CTR_WIDTH-1:0] o_head_ctr,
  output logic                 o_full,
  output logic                 o_empty
);

  bp_upd_entry_t   r_mem [QDEPTH];
  logic [QIDX-1:0] r_head;
  logic [QIDX-1:0] r_tail;
  logic [QIDX:0]   r_count;
  logic [QIDX-1:0] w_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < QDEPTH; i++) r_mem[i] <= '{valid: 1'b0, index: '0, ctr: CTR_RESET};
    end else begin
      if (i_upd_en) r_mem[i_upd_ptr].ctr <= i_upd_ctr;
      if (i_pop) begin
        r_mem[r_head].valid <= 1'b0;
        r_head              <= r_head + 1'b1;
      end
      if (i_push) begin
        r_mem[r_tail] <= '{valid: 1'b1, index: i_push_index, ctr: i_push_ctr};
        r_tail        <= r_tail + 1'b1;
      end
      r_count <= r_count + (QIDX+1)'(i_push) - (QIDX+1)'(i_pop);
    end
  end

  // Walk oldest to youngest so the last hit is the youngest matching entry.
  always_comb begin
    o_match         = 1'b0;
    o_match_ptr     = r_head;
    o_match_is_head = 1'b0;
    w_ptr           = r_head;
    for (int k = 0; k < QDEPTH; k++) begin
      w_ptr = r_head + QIDX'(k);
      if (((QIDX+1)'(k) < r_count) && r_mem[w_ptr].valid && (r_mem[w_ptr].index == i_srch_index)) begin
        o_match         = 1'b1;
        o_match_ptr     = w_ptr;
        o_match_is_head = (k == 0);
      end
    end
  end

  assign o_match_ctr  = r_mem[o_match_ptr].ctr;
  assign o_head_index = r_mem[r_head].index;
  assign o_head_ctr   = r_mem[r_head].ctr;
  assign o_full       = (r_count == (QIDX+1)'(QDEPTH));
  assign o_empty      = (r_count == '0);

endmodule

// File: rtl/bp_update_queue.sv
// Bimodal counter update queue: saturate, coalesce by index, one RAM write/cycle; accepted updates write >=1 cycle later, not ready when full or in reset.
// Build option BP_UPD_STATS_EN adds coalesce and full-stall counters (stat_coalesce_o, stat_full_o).
module bp_update_queue
  import bp_pkg::*;
#(
  parameter int QDEPTH = BP_QDEPTH,
  parameter int QIDX   = BP_QIDX
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 upd_valid_i,
  input  logic [INDEX-1:0]     upd_index_i,
  input  logic [CTR_WIDTH-1:0] upd_ctr_i,
  input  logic                 upd_taken_i,
  output logic                 upd_ready_o,
  input  logic                 stall_i,
  output logic [INDEX-1:0]     wr_index_o,
  output logic [CTR_WIDTH-1:0] wr_data_o,
  output logic                 wr_en_o
`ifdef BP_UPD_STATS_EN
  ,
  output logic [31:0]          stat_coalesce_o,
  output logic [31:0]          stat_full_o
`endif
);

  logic                 w_full;
  logic                 w_empty;
  logic                 w_match;
  logic [QIDX-1:0]      w_match_ptr;
  logic                 w_match_head;
  logic [CTR_WIDTH-1:0] w_match_ctr;
  logic [INDEX-1:0]     w_head_index;
  logic [CTR_WIDTH-1:0] w_head_ctr;
  logic                 w_drain;
  logic                 w_accept;
  logic                 w_coalesce;
  logic                 w_alloc;
  logic [CTR_WIDTH-1:0] w_base;
  logic [CTR_WIDTH-1:0] w_new;

  assign upd_ready_o = !w_full && !reset;
  assign w_drain     = !w_empty && !stall_i && !reset;
  assign w_accept    = upd_valid_i && upd_ready_o;

  // A queued value is newer than the predict-time read, so it wins as the base.
  assign w_base = w_match ? w_match_ctr : upd_ctr_i;
  assign w_new  = bp_sat_next(w_base, upd_taken_i);

  // The head leaving this cycle cannot absorb an update; it gets a fresh entry instead.
  assign w_coalesce = w_accept && w_match && !(w_match_head && w_drain);
  assign w_alloc    = w_accept && !w_coalesce;

  assign wr_en_o    = w_drain;
  assign wr_index_o = reset ? '0 : w_head_index;
  assign wr_data_o  = reset ? CTR_RESET : w_head_ctr;

  bp_upd_fifo #(
    .QDEPTH (QDEPTH),
    .QIDX   (QIDX)
  ) u_fifo (
    .clk             (clk),
    .reset           (reset),
    .i_push          (w_alloc),
    .i_push_index    (upd_index_i),
    .i_push_ctr      (w_new),
    .i_pop           (w_drain),
    .i_upd_en        (w_coalesce),
    .i_upd_ptr       (w_match_ptr),
    .i_upd_ctr       (w_new),
    .i_srch_index    (upd_index_i),
    .o_match         (w_match),
    .o_match_ptr     (w_match_ptr),
    .o_match_is_head (w_match_head),
    .o_match_ctr     (w_match_ctr),
    .o_head_index    (w_head_index),
    .o_head_ctr      (w_head_ctr),
    .o_full          (w_full),
    .o_empty         (w_empty)
  );

`ifdef BP_UPD_STATS_EN
  logic [31:0] r_stat_coalesce;
  logic [31:0] r_stat_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_coalesce <= '0;
      r_stat_full     <= '0;
    end else begin
      if (w_coalesce && (r_stat_coalesce != '1)) r_stat_coalesce <= r_stat_coalesce + 32'd1;
      if (upd_valid_i && !upd_ready_o && (r_stat_full != '1)) r_stat_full <= r_stat_full + 32'd1;
    end
  end

  assign stat_coalesce_o = r_stat_coalesce;
  assign stat_full_o     = r_stat_full;
`endif

endmodule

// File: tb/tb_bp_update_queue.sv
// Bench for bp_update_queue: directed vector table, corner sequences, and random traffic against a queue model.
module tb_bp_update_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic       upd_valid_i;
  logic [5:0] upd_index_i;
  logic [1:0] upd_ctr_i;
  logic       upd_taken_i;
  logic       upd_ready_o;
  logic       stall_i;
  logic [5:0] wr_index_o;
  logic [1:0] wr_data_o;
  logic       wr_en_o;
`ifdef BP_UPD_STATS_EN
  logic [31:0] stat_coalesce_o;
  logic [31:0] stat_full_o;
`endif

  bp_update_queue dut (
    .clk         (clk),
    .reset       (reset),
    .upd_valid_i (upd_valid_i),
    .upd_index_i (upd_index_i),
    .upd_ctr_i   (upd_ctr_i),
    .upd_taken_i (upd_taken_i),
    .upd_ready_o (upd_ready_o),
    .stall_i     (stall_i),
    .wr_index_o  (wr_index_o),
    .wr_data_o   (wr_data_o),
    .wr_en_o     (wr_en_o)
`ifdef BP_UPD_STATS_EN
    ,
    .stat_coalesce_o (stat_coalesce_o),
    .stat_full_o     (stat_full_o)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    int idx;
    int ctr;
    bit tk;
    int exp;
  } vec_t;
  vec_t vt [7];

  typedef struct {
    int idx;
    int ctr;
  } ment_t;
  ment_t mq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int sat(input int b, input bit t);
    if (t) return (b + 1 > 3) ? 3 : b + 1;
    return (b - 1 < 0) ? 0 : b - 1;
  endfunction

  task automatic drive(input bit v, input int idx, input int ctr, input bit tk);
    upd_valid_i = v;
    upd_index_i = 6'(idx);
    upd_ctr_i   = 2'(ctr);
    upd_taken_i = tk;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Queue-level reference: evaluate one cycle of the given inputs, then apply its effect.
  task automatic model_step(input bit v, input int idx, input int ctr, input bit tk, input bit st);
    int  j;
    int  nv;
    bit  drain;
    drain = (mq.size() > 0) && !st;
    if (v && mq.size() < 4) begin
      j = -1;
      for (int k = 0; k < mq.size(); k++) if (mq[k].idx == idx) j = k;
      nv = sat((j >= 0) ? mq[j].ctr : ctr, tk);
      if (j >= 0 && !(j == 0 && drain)) mq[j].ctr = nv;
      else mq.push_back('{idx: idx, ctr: nv});
    end
    if (drain) void'(mq.pop_front());
  endtask

  initial begin
    bit  pend;
    bit  v;
    int  idx;
    int  ctr;
    bit  tk;
    bit  st;
    bit  exp_rdy;
    bit  exp_en;

    vt[0] = '{idx: 5,  ctr: 2, tk: 1'b1, exp: 3};
    vt[1] = '{idx: 1,  ctr: 3, tk: 1'b1, exp: 3};
    vt[2] = '{idx: 2,  ctr: 0, tk: 1'b0, exp: 0};
    vt[3] = '{idx: 3,  ctr: 1, tk: 1'b0, exp: 0};
    vt[4] = '{idx: 4,  ctr: 1, tk: 1'b1, exp: 2};
    vt[5] = '{idx: 10, ctr: 3, tk: 1'b0, exp: 2};
    vt[6] = '{idx: 63, ctr: 0, tk: 1'b1, exp: 1};

    reset   = 1'b1;
    stall_i = 1'b0;
    drive(1'b1, 12, 1, 1'b1);
    cyc();
    #1;
    chk("rst_ready", upd_ready_o, 0);
    chk("rst_wr_en", wr_en_o, 0);
    chk("rst_wr_index", wr_index_o, 0);
    chk("rst_wr_data", wr_data_o, 2);
    cyc();
    reset = 1'b0;
    drive(1'b0, 0, 0, 1'b0);
    #1;
    chk("post_rst_ready", upd_ready_o, 1);
    chk("post_rst_wr_en", wr_en_o, 0);

    // Single updates into an empty queue: one write the following cycle, then idle.
    for (int i = 0; i < 7; i++) begin
      cyc();
      drive(1'b1, vt[i].idx, vt[i].ctr, vt[i].tk);
      #1;
      chk("vec_no_bypass", wr_en_o, 0);
      cyc();
      drive(1'b0, 0, 0, 1'b0);
      #1;
      chk("vec_wr_en", wr_en_o, 1);
      chk("vec_wr_index", wr_index_o, vt[i].idx);
      chk("vec_wr_data", wr_data_o, vt[i].exp);
      cyc();
      #1;
      chk("vec_empty_after", wr_en_o, 0);
    end

    // Three stalled updates to one index collapse into a single write.
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      drive(1'b1, 7, 1, 1'b1);
      #1;
      chk("coal_ready", upd_ready_o, 1);
    end
    cyc();
    drive(1'b0, 0, 0, 1'b0);
    stall_i = 1'b0;
    #1;
    chk("coal_wr_en", wr_en_o, 1);
    chk("coal_wr_index", wr_index_o, 7);
    chk("coal_wr_data", wr_data_o, 3);
    cyc();
    #1;
    chk("coal_single_write", wr_en_o, 0);

    // Fill to capacity under stall; fifth update waits for the first drain.
    stall_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      drive(1'b1, 20 + i, 1, 1'b0);
    end
    cyc();
    drive(1'b1, 24, 2, 1'b1);
    #1;
    chk("full_ready", upd_ready_o, 0);
    cyc();
    #1;
    chk("full_ready_hold", upd_ready_o, 0);
    cyc();
    stall_i = 1'b0;
    #1;
    chk("full_no_passthru", upd_ready_o, 0);
    chk("full_wr0_en", wr_en_o, 1);
    chk("full_wr0_index", wr_index_o, 20);
    cyc();
    #1;
    chk("full_ready_after_drain", upd_ready_o, 1);
    chk("full_wr1_index", wr_index_o, 21);
    cyc();
    drive(1'b0, 0, 0, 1'b0);
    #1;
    chk("full_wr2_index", wr_index_o, 22);
    chk("full_wr2_data", wr_data_o, 0);
    cyc();
    #1;
    chk("full_wr3_index", wr_index_o, 23);
    cyc();
    #1;
    chk("full_wr4_en", wr_en_o, 1);
    chk("full_wr4_index", wr_index_o, 24);
    chk("full_wr4_data", wr_data_o, 3);
    cyc();
    #1;
    chk("full_drained", wr_en_o, 0);

    // Update hitting the draining head takes its value as base and allocates.
    stall_i = 1'b1;
    drive(1'b1, 9, 1, 1'b1);
    cyc();
    stall_i = 1'b0;
    drive(1'b1, 9, 1, 1'b0);
    #1;
    chk("hd_wr0_index", wr_index_o, 9);
    chk("hd_wr0_data", wr_data_o, 2);
    cyc();
    drive(1'b0, 0, 0, 1'b0);
    #1;
    chk("hd_wr1_en", wr_en_o, 1);
    chk("hd_wr1_index", wr_index_o, 9);
    chk("hd_wr1_data", wr_data_o, 1);
    cyc();
    #1;
    chk("hd_empty", wr_en_o, 0);

    // Reset with pending entries discards them.
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      drive(1'b1, 30 + i, 2, 1'b1);
    end
    cyc();
    drive(1'b0, 0, 0, 1'b0);
    stall_i = 1'b0;
    reset   = 1'b1;
    #1;
    chk("mid_rst_ready", upd_ready_o, 0);
    chk("mid_rst_wr_en", wr_en_o, 0);
    cyc();
    reset = 1'b0;
    #1;
    chk("mid_rst_after_wr_en", wr_en_o, 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      #1;
      chk("mid_rst_no_writes", wr_en_o, 0);
    end

    // Random traffic on a small index range to exercise coalescing and back-pressure.
    mq.delete();
    pend = 1'b0;
    v = 1'b0; idx = 0; ctr = 0; tk = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      if (!pend) begin
        v   = ($urandom_range(0, 99) < 65);
        idx = $urandom_range(0, 7);
        ctr = $urandom_range(0, 3);
        tk  = $urandom_range(0, 1);
      end
      st = ($urandom_range(0, 99) < 40);
      drive(v, idx, ctr, tk);
      stall_i = st;
      #1;
      exp_rdy = (mq.size() < 4);
      exp_en  = (mq.size() > 0) && !st;
      chk("rnd_ready", upd_ready_o, exp_rdy);
      chk("rnd_wr_en", wr_en_o, exp_en);
      if (exp_en) begin
        chk("rnd_wr_index", wr_index_o, mq[0].idx);
        chk("rnd_wr_data", wr_data_o, mq[0].ctr);
      end
      pend = v && !exp_rdy;
      model_step(v, idx, ctr, tk, st);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
